mc_control: RTL and testbench

- Multi-cycle MIPS control unit: Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath mux select, write enable and the 4-bit alu_op code into the core ALU; consumes the ALU zero flag for branches.
- Sits between the instruction register (opcode/funct) and the shared datapath. Replaces single-cycle combinational decode in the multi-cycle core variant.

---
 rtl/mc_control.sv | 221 ++++++++++++++++++++++
 tb/tb_mc_control.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multi-cycle MIPS control unit (Moore FSM)
//
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the shared datapath. Optional feature macro: MC_LOGIMM_EN
// (adds andi/ori through a LOGIEXEC state).
//
// Ports:
//   clk, rst_n      core clock (rising edge), asynchronous active-low reset
//   opcode, funct   instr[31:26] / instr[5:0] from the instruction register
//   zero            ALU zero flag, consumed in BRANCH
//   alu_op          AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111
//   alu_src_a/b     ALU operand selects
//   pc_src, pc_en   PC next-value select and write enable
//   iord            memory address select (0=PC, 1=ALUOut)
//   ir_write        instruction register load
//   mem_write       data memory write
//   reg_dst, mem_to_reg, reg_write   register file write controls
//   illegal         unsupported opcode/funct seen in DECODE
//   retired         completed-instruction count (wraps)
`timescale 1ns/1ps

module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic [3:0]       alu_op,
  output logic             alu_src_a,
  output logic [2:0]       alu_src_b,
  output logic [1:0]       pc_src,
  output logic             pc_en,
  output logic             iord,
  output logic             ir_write,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
`ifdef MC_LOGIMM_EN
    S_LOGIEXEC = 4'd12,
`endif
    S_JUMP     = 4'd11
  } state_t;

  state_t state, state_next;

  logic       pc_write;
  logic       branch;
  logic       ir_load;
  logic       mem_wr;
  logic       reg_wr;
  logic       funct_ok;
  logic [3:0] funct_alu;
  logic       terminal;

  // R-type funct lookup shared by DECODE (legality) and EXECUTE (alu_op)
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = S_FETCH;
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = 3'b000;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    ir_load    = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    illegal    = 1'b0;
    terminal   = 1'b0;
    case (state)
      S_FETCH: begin
        ir_load    = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = 3'b001;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_b = 3'b011;
        case (opcode)
          6'b100011, 6'b101011: state_next = S_MEMADR;
          6'b000000: begin
            if (funct_ok) state_next = S_EXECUTE;
            else          illegal    = 1'b1;
          end
          6'b000100: state_next = S_BRANCH;
          6'b001000: state_next = S_ADDIEXEC;
          6'b000010: state_next = S_JUMP;
`ifdef MC_LOGIMM_EN
          6'b001100, 6'b001101: state_next = S_LOGIEXEC;
`endif
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 3'b010;
        // IR is only loaded in FETCH, so opcode still identifies lw vs sw
        state_next = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        terminal   = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        mem_wr   = 1'b1;
        terminal = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_op     = funct_alu;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst  = 1'b1;
        reg_wr   = 1'b1;
        terminal = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        terminal  = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 3'b010;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_wr   = 1'b1;
        terminal = 1'b1;
      end
`ifdef MC_LOGIMM_EN
      S_LOGIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 3'b100;
        alu_op     = opcode[0] ? ALU_OR : ALU_AND;
        state_next = S_ADDIWB;
      end
`endif
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        terminal = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write strobes are gated by rst_n so nothing escapes while reset is held,
  // even though the state register already shows FETCH.
  assign pc_en     = rst_n & (pc_write | (branch & zero));
  assign ir_write  = rst_n & ir_load;
  assign mem_write = rst_n & mem_wr;
  assign reg_write = rst_n & reg_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (terminal) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - randomized self-checking bench for mc_control
`timescale 1ns/1ps

module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;

  logic [3:0]  alu_op, alu_op4;
  logic        alu_src_a, alu_src_a4;
  logic [2:0]  alu_src_b, alu_src_b4;
  logic [1:0]  pc_src, pc_src4;
  logic        pc_en, pc_en4, iord, iord4, ir_write, ir_write4;
  logic        mem_write, mem_write4, reg_dst, reg_dst4;
  logic        mem_to_reg, mem_to_reg4, reg_write, reg_write4;
  logic        illegal, illegal4;
  logic [31:0] retired;
  logic [3:0]  retired4;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .pc_en(pc_en), .iord(iord), .ir_write(ir_write),
    .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .illegal(illegal), .retired(retired)
  );

  mc_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(alu_op4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4),
    .pc_src(pc_src4), .pc_en(pc_en4), .iord(iord4), .ir_write(ir_write4),
    .mem_write(mem_write4), .reg_dst(reg_dst4), .mem_to_reg(mem_to_reg4),
    .reg_write(reg_write4), .illegal(illegal4), .retired(retired4)
  );

  always #5 clk = ~clk;

  wire [17:0] act_vec  = {alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, ir_write,
                          mem_write, reg_dst, mem_to_reg, reg_write, illegal};
  wire [17:0] act_vec4 = {alu_op4, alu_src_a4, alu_src_b4, pc_src4, pc_en4, iord4, ir_write4,
                          mem_write4, reg_dst4, mem_to_reg4, reg_write4, illegal4};

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD_ = 4'b0010;
  localparam logic [3:0] SUB_ = 4'b0110, SLT_ = 4'b0111;
  localparam logic [7:0] F_PCEN = 8'h80, F_IORD = 8'h40, F_IRW = 8'h20, F_MW = 8'h10;
  localparam logic [7:0] F_RD = 8'h08, F_M2R = 8'h04, F_RW = 8'h02, F_ILL = 8'h01;
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5;
  localparam int C_LOGI = 6, C_ILL = 7;

  int          n_checks = 0;
  int          n_pass = 0;
  logic        exp_valid = 1'b0;
  logic [17:0] exp_vec = '0;
  logic [31:0] exp_count = '0;
  logic [17:0] seq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (exp_valid) begin
      check("outputs", 64'(act_vec), 64'(exp_vec));
      check("outputs_cnt4", 64'(act_vec4), 64'(exp_vec));
      check("retired", 64'(retired), 64'(exp_count));
      check("retired_cnt4", 64'(retired4), 64'(exp_count[3:0]));
    end
  end

  function automatic logic [17:0] mkv(logic [3:0] alu, logic sa, logic [2:0] sb,
                                      logic [1:0] ps, logic [7:0] flags);
    return {alu, sa, sb, ps, flags};
  endfunction

  function automatic logic funct_ok(logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      6'b100010: return SUB_;
      6'b100100: return AND_;
      6'b100101: return OR_;
      6'b101010: return SLT_;
      default:   return ADD_;
    endcase
  endfunction

  function automatic int classify(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return funct_ok(fn) ? C_R : C_ILL;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
`ifdef MC_LOGIMM_EN
      6'b001100, 6'b001101: return C_LOGI;
`endif
      default: return C_ILL;
    endcase
  endfunction

  // Expected per-cycle output vectors for one instruction, from the phase table
  function automatic void build(logic [5:0] op, logic [5:0] fn, logic z);
    int c;
    c = classify(op, fn);
    seq.delete();
    seq.push_back(mkv(ADD_, 1'b0, 3'b001, 2'b00, F_PCEN | F_IRW));
    seq.push_back(mkv(ADD_, 1'b0, 3'b011, 2'b00, (c == C_ILL) ? F_ILL : 8'h00));
    case (c)
      C_LW: begin
        seq.push_back(mkv(ADD_, 1'b1, 3'b010, 2'b00, 8'h00));
        seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b00, F_IORD));
        seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b00, F_M2R | F_RW));
      end
      C_SW: begin
        seq.push_back(mkv(ADD_, 1'b1, 3'b010, 2'b00, 8'h00));
        seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b00, F_IORD | F_MW));
      end
      C_R: begin
        seq.push_back(mkv(alu_of(fn), 1'b1, 3'b000, 2'b00, 8'h00));
        seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b00, F_RD | F_RW));
      end
      C_BEQ: seq.push_back(mkv(SUB_, 1'b1, 3'b000, 2'b01, z ? F_PCEN : 8'h00));
      C_ADDI: begin
        seq.push_back(mkv(ADD_, 1'b1, 3'b010, 2'b00, 8'h00));
        seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b00, F_RW));
      end
      C_J: seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b10, F_PCEN));
      C_LOGI: begin
        seq.push_back(mkv(op[0] ? OR_ : AND_, 1'b1, 3'b100, 2'b00, 8'h00));
        seq.push_back(mkv(ADD_, 1'b0, 3'b000, 2'b00, F_RW));
      end
      default: ;
    endcase
  endfunction

  // Entered #1 after the edge that put the DUT in FETCH; returns likewise.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    int c;
    c = classify(op, fn);
    build(op, fn, z);
    for (int i = 0; i < seq.size(); i++) begin
      opcode  = op;
      funct   = fn;
      zero    = (c == C_BEQ && i == 2) ? z : 1'($urandom);
      exp_vec = seq[i];
      @(posedge clk);
      #1;
    end
    if (c != C_ILL) exp_count = exp_count + 1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    exp_count = '0;
    exp_vec   = mkv(ADD_, 1'b0, 3'b001, 2'b00, 8'h00);
    exp_valid = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  logic [5:0] lat_ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000,
                             6'b000100, 6'b000010, 6'b111111};
  int         lat_exp[7] = '{5, 4, 4, 4, 3, 3, 2};
  logic [5:0] rnd_ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b001100, 6'b001101};
  logic [5:0] rnd_fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;

    // Pin the model against hand-derived latencies and a known alu code
    for (int i = 0; i < 7; i++) begin
      build(lat_ops[i], 6'b100000, 1'b1);
      check($sformatf("latency_op%b", lat_ops[i]), 64'(seq.size()), 64'(lat_exp[i]));
    end
    build(6'b000000, 6'b100010, 1'b0);
    check("model_sub_code", 64'(seq[2][17:14]), 64'(4'b0110));

    do_reset(3);
    check("reset_retired", 64'(retired), 64'd0);

    run_instr(6'b000000, 6'b100000, 1'b0);
    run_instr(6'b000000, 6'b100010, 1'b0);
    check("retired_after_rtype", 64'(retired), 64'd2);
    run_instr(6'b100011, 6'b000000, 1'b0);
    run_instr(6'b101011, 6'b000000, 1'b0);
    check("retired_after_lwsw", 64'(retired), 64'd4);
    run_instr(6'b000100, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b0);
    check("retired_after_beq", 64'(retired), 64'd6);
    run_instr(6'b111111, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b000111, 1'b0);
    check("retired_after_illegal", 64'(retired), 64'd6);
    run_instr(6'b001100, 6'b000000, 1'b0);
    run_instr(6'b001101, 6'b000000, 1'b0);

    // Reset asserted while the DUT sits in MEMWR
    build(6'b101011, 6'b000000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      opcode = 6'b101011; funct = '0; exp_vec = seq[i];
      @(posedge clk);
      #1;
    end
    exp_vec = seq[3];
    @(negedge clk);
    #1 rst_n = 1'b0;
    exp_count = '0;
    exp_vec   = mkv(ADD_, 1'b0, 3'b001, 2'b00, 8'h00);
    #1;
    check("memwr_reset_mem_write", 64'(mem_write), 64'd0);
    check("memwr_reset_vec", 64'(act_vec), 64'(exp_vec));
    check("memwr_reset_retired", 64'(retired), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_instr(6'b000010, 6'b000000, 1'b0);
    check("jump16_cnt4_wrap", 64'(retired4), 64'd0);
    check("jump16_cnt32", 64'(retired), 64'd16);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) < 8) op = rnd_ops[$urandom_range(0, 7)];
      else                          op = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn = rnd_fns[$urandom_range(0, 4)];
      else                           fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom));
    end

    exp_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
